// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response, decode handoff and redirect signals of fetch_unit.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        consume;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_timeout;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_valid,
        input  consume, redirect, redirect_pc,
        output inst_valid, inst, opcode, funct, pc, pc_plus4, fetch_timeout
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_valid,
        output consume, redirect, redirect_pc,
        input  inst_valid, inst, opcode, funct, pc, pc_plus4, fetch_timeout
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM feeding decode; FETCH_TIMEOUT_EN adds a 15-cycle re-issue timer.
// Latency: 1 cycle reset->first request, consume->next request, imem_valid->inst_valid.
// Backpressure: the fetched word is held until consume or redirect; memory responses cannot be stalled.
module fetch_unit (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master fu
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        drop_q, drop_d;
    logic [31:0] redirect_tgt;
    logic        timeout_hit;

    assign redirect_tgt = fu.redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] tmo_cnt_q, tmo_cnt_d;

    // The 15th silent S_WAIT cycle is the one that sees tmo_cnt_q == 14.
    assign timeout_hit = (state_q == S_WAIT) && !fu.imem_valid && (tmo_cnt_q == 4'd14);

    always_comb begin
        tmo_cnt_d = 4'd0;
        if ((state_q == S_WAIT) && !fu.imem_valid && !timeout_hit) begin
            tmo_cnt_d = tmo_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= 4'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (fu.redirect) begin
                    pc_d = redirect_tgt;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                // The request already left at the old pc, so its response must be thrown away.
                if (fu.redirect) begin
                    pc_d   = redirect_tgt;
                    drop_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (fu.imem_valid) begin
                    if (fu.redirect) begin
                        pc_d    = redirect_tgt;
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = fu.imem_rdata;
                        state_d = S_HOLD;
                    end
                end else begin
                    if (fu.redirect) begin
                        pc_d   = redirect_tgt;
                        drop_d = 1'b1;
                    end
                    if (timeout_hit) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (fu.redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (fu.consume) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= 32'h0000_0000;
            inst_q  <= 32'h0000_0000;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            drop_q  <= drop_d;
        end
    end

    // Strobes are masked while reset is high so nothing leaks out before the reset edge lands.
    assign fu.imem_req      = !reset && (state_q == S_REQ);
    assign fu.imem_addr     = pc_q;
    assign fu.inst_valid    = !reset && (state_q == S_HOLD);
    assign fu.inst          = inst_q;
    assign fu.opcode        = inst_q[31:26];
    assign fu.funct         = inst_q[5:0];
    assign fu.pc            = pc_q;
    assign fu.pc_plus4      = pc_q + 32'd4;
    assign fu.fetch_timeout = !reset && timeout_hit;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run scored against a transaction-level fetch model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    fetch_unit_if fu();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .fu    (fu.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic idle_inputs();
        fu.imem_valid  = 1'b0;
        fu.imem_rdata  = 32'h0;
        fu.consume     = 1'b0;
        fu.redirect    = 1'b0;
        fu.redirect_pc = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        total++; if (fu.inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%b want=0", fu.inst_valid); end
        total++; if (fu.imem_req !== 1'b0) begin bad++; $display("FAIL rst_imem_req got=%b want=0", fu.imem_req); end
        total++; if (fu.fetch_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", fu.fetch_timeout); end
        total++; if (fu.pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", fu.pc); end
        total++; if (fu.inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h want=0", fu.inst); end
        reset = 1'b0;
        #1;
        total++; if (fu.imem_req !== 1'b0) begin bad++; $display("FAIL rst_idle_req got=%b want=0", fu.imem_req); end
        @(negedge clk);
        total++; if (fu.imem_req !== 1'b1 || fu.imem_addr !== 32'h0) begin
            bad++; $display("FAIL rst_first_req got=%b/%h want=1/00000000", fu.imem_req, fu.imem_addr);
        end
    endtask

    task automatic test_basic_fetch();
        @(negedge clk);
        total++; if (fu.imem_req !== 1'b0 || fu.inst_valid !== 1'b0) begin
            bad++; $display("FAIL basic_wait got=%b/%b want=0/0", fu.imem_req, fu.inst_valid);
        end
        fu.imem_valid = 1'b1; fu.imem_rdata = 32'h8C22_0004;
        @(negedge clk);
        fu.imem_valid = 1'b0; fu.imem_rdata = 32'h0;
        total++; if (fu.inst_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", fu.inst_valid); end
        total++; if (fu.inst !== 32'h8C22_0004) begin bad++; $display("FAIL basic_inst got=%h want=8c220004", fu.inst); end
        total++; if (fu.opcode !== 6'b100011 || fu.funct !== 6'b000100) begin
            bad++; $display("FAIL basic_slices got=%b/%b want=100011/000100", fu.opcode, fu.funct);
        end
        total++; if (fu.pc !== 32'h0 || fu.pc_plus4 !== 32'h4) begin
            bad++; $display("FAIL basic_pc got=%h/%h want=0/4", fu.pc, fu.pc_plus4);
        end
        for (int i = 0; i < 3; i++) begin
            fu.imem_valid = 1'b1; fu.imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        fu.imem_valid = 1'b0;
        total++; if (fu.inst_valid !== 1'b1 || fu.inst !== 32'h8C22_0004 || fu.pc !== 32'h0 || fu.imem_req !== 1'b0) begin
            bad++; $display("FAIL hold_stable got=%b/%h/%h want=1/8c220004/0", fu.inst_valid, fu.inst, fu.pc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 32'(4 * (i + 1));
            fu.consume = 1'b1;
            @(negedge clk);
            fu.consume = 1'b0;
            total++; if (fu.imem_req !== 1'b1 || fu.imem_addr !== a || fu.inst_valid !== 1'b0) begin
                bad++; $display("FAIL b2b_req got=%b/%h want=1/%h", fu.imem_req, fu.imem_addr, a);
            end
            @(negedge clk);
            fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(a);
            @(negedge clk);
            fu.imem_valid = 1'b0;
            total++; if (fu.inst_valid !== 1'b1 || fu.pc !== a || fu.inst !== mem_word(a)) begin
                bad++; $display("FAIL b2b_hold got=%b/%h/%h want=1/%h/%h", fu.inst_valid, fu.pc, fu.inst, a, mem_word(a));
            end
        end
    endtask

    task automatic test_redirect();
        // redirect while waiting, stale response later
        fu.consume = 1'b1;
        @(negedge clk);
        fu.consume = 1'b0;
        @(negedge clk);
        fu.redirect = 1'b1; fu.redirect_pc = 32'h0000_0043;
        @(negedge clk);
        fu.redirect = 1'b0;
        total++; if (fu.inst_valid !== 1'b0 || fu.imem_req !== 1'b0) begin
            bad++; $display("FAIL rdw_drop_wait got=%b/%b want=0/0", fu.inst_valid, fu.imem_req);
        end
        fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(32'h10);
        @(negedge clk);
        fu.imem_valid = 1'b0;
        total++; if (fu.imem_req !== 1'b1 || fu.imem_addr !== 32'h40 || fu.inst_valid !== 1'b0) begin
            bad++; $display("FAIL rdw_reissue got=%b/%h/%b want=1/00000040/0", fu.imem_req, fu.imem_addr, fu.inst_valid);
        end
        @(negedge clk);
        fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(32'h40);
        @(negedge clk);
        fu.imem_valid = 1'b0;
        total++; if (fu.inst_valid !== 1'b1 || fu.inst !== mem_word(32'h40) || fu.pc !== 32'h40) begin
            bad++; $display("FAIL rdw_new_inst got=%b/%h/%h want=1/%h/00000040", fu.inst_valid, fu.inst, fu.pc, mem_word(32'h40));
        end
        // redirect coinciding with the response
        fu.consume = 1'b1;
        @(negedge clk);
        fu.consume = 1'b0;
        total++; if (fu.imem_addr !== 32'h44) begin bad++; $display("FAIL rdv_req got=%h want=00000044", fu.imem_addr); end
        @(negedge clk);
        fu.redirect = 1'b1; fu.redirect_pc = 32'h0000_0101;
        fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(32'h44);
        @(negedge clk);
        fu.redirect = 1'b0; fu.imem_valid = 1'b0;
        total++; if (fu.imem_req !== 1'b1 || fu.imem_addr !== 32'h100 || fu.inst_valid !== 1'b0) begin
            bad++; $display("FAIL rdv_reissue got=%b/%h/%b want=1/00000100/0", fu.imem_req, fu.imem_addr, fu.inst_valid);
        end
        // redirect during the request cycle itself
        fu.redirect = 1'b1; fu.redirect_pc = 32'h0000_0202;
        @(negedge clk);
        fu.redirect = 1'b0;
        fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(32'h100);
        @(negedge clk);
        fu.imem_valid = 1'b0;
        total++; if (fu.imem_req !== 1'b1 || fu.imem_addr !== 32'h200) begin
            bad++; $display("FAIL rdr_reissue got=%b/%h want=1/00000200", fu.imem_req, fu.imem_addr);
        end
        @(negedge clk);
        fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(32'h200);
        @(negedge clk);
        fu.imem_valid = 1'b0;
        total++; if (fu.inst_valid !== 1'b1 || fu.inst !== mem_word(32'h200) || fu.pc !== 32'h200) begin
            bad++; $display("FAIL rdr_inst got=%b/%h/%h want=1/%h/00000200", fu.inst_valid, fu.inst, fu.pc, mem_word(32'h200));
        end
    endtask

    task automatic test_wrap();
        fu.redirect = 1'b1; fu.consume = 1'b1; fu.redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        fu.redirect = 1'b0; fu.consume = 1'b0;
        total++; if (fu.imem_req !== 1'b1 || fu.imem_addr !== 32'hFFFF_FFFC || fu.inst_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_req got=%b/%h/%b want=1/fffffffc/0", fu.imem_req, fu.imem_addr, fu.inst_valid);
        end
        @(negedge clk);
        fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(32'hFFFF_FFFC);
        @(negedge clk);
        fu.imem_valid = 1'b0;
        total++; if (fu.inst_valid !== 1'b1 || fu.pc !== 32'hFFFF_FFFC || fu.pc_plus4 !== 32'h0) begin
            bad++; $display("FAIL wrap_hold got=%b/%h/%h want=1/fffffffc/00000000", fu.inst_valid, fu.pc, fu.pc_plus4);
        end
        fu.consume = 1'b1;
        @(negedge clk);
        fu.consume = 1'b0;
        total++; if (fu.imem_req !== 1'b1 || fu.imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_next got=%b/%h want=1/00000000", fu.imem_req, fu.imem_addr);
        end
        @(negedge clk);
        fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(32'h0);
        @(negedge clk);
        fu.imem_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                fu.consume = 1'b1;
                @(negedge clk);
                fu.consume = 1'b0;
                @(negedge clk);
                fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(32'h4);
            end
            reset = 1'b1;
            @(negedge clk);
            fu.imem_valid = 1'b0;
            total++; if (fu.inst_valid !== 1'b0 || fu.pc !== 32'h0 || fu.imem_req !== 1'b0) begin
                bad++; $display("FAIL mid_rst%0d got=%b/%h/%b want=0/00000000/0", pass, fu.inst_valid, fu.pc, fu.imem_req);
            end
            reset = 1'b0;
            fu.imem_valid = 1'b1; fu.imem_rdata = 32'hBAD0_0001;
            #1;
            total++; if (fu.inst_valid !== 1'b0 || fu.imem_req !== 1'b0) begin
                bad++; $display("FAIL mid_idle%0d got=%b/%b want=0/0", pass, fu.inst_valid, fu.imem_req);
            end
            @(negedge clk);
            total++; if (fu.imem_req !== 1'b1 || fu.imem_addr !== 32'h0 || fu.inst_valid !== 1'b0) begin
                bad++; $display("FAIL mid_req%0d got=%b/%h/%b want=1/00000000/0", pass, fu.imem_req, fu.imem_addr, fu.inst_valid);
            end
            @(negedge clk);
            fu.imem_valid = 1'b0;
            @(negedge clk);
            total++; if (fu.inst_valid !== 1'b0) begin bad++; $display("FAIL mid_late%0d got=%b want=0", pass, fu.inst_valid); end
            fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(32'h0);
            @(negedge clk);
            fu.imem_valid = 1'b0;
            total++; if (fu.inst_valid !== 1'b1 || fu.inst !== mem_word(32'h0) || fu.pc !== 32'h0) begin
                bad++; $display("FAIL mid_refetch%0d got=%b/%h/%h want=1/%h/0", pass, fu.inst_valid, fu.inst, fu.pc, mem_word(32'h0));
            end
        end
    endtask

    task automatic test_timeout();
        int          to_cnt;
        int          to_at;
        int          req_at;
        logic [31:0] req_addr;
        to_cnt = 0; to_at = -1; req_at = -1; req_addr = 32'h0;
        fu.redirect = 1'b1; fu.redirect_pc = 32'h0000_0500;
        @(negedge clk);
        fu.redirect = 1'b0;
        total++; if (fu.imem_req !== 1'b1 || fu.imem_addr !== 32'h500) begin
            bad++; $display("FAIL to_first_req got=%b/%h want=1/00000500", fu.imem_req, fu.imem_addr);
        end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            #1;
            if (fu.fetch_timeout === 1'b1) begin
                to_cnt++;
                if (to_at < 0) to_at = k;
            end
            if (fu.imem_req === 1'b1 && req_at < 0) begin
                req_at = k; req_addr = fu.imem_addr;
            end
        end
`ifdef FETCH_TIMEOUT_EN
        total++; if (to_cnt != 1 || to_at != 15) begin bad++; $display("FAIL to_pulse got=%0d@%0d want=1@15", to_cnt, to_at); end
        total++; if (req_at != 16 || req_addr !== 32'h500) begin
            bad++; $display("FAIL to_reissue got=%0d/%h want=16/00000500", req_at, req_addr);
        end
`else
        total++; if (to_cnt != 0) begin bad++; $display("FAIL to_pulse got=%0d want=0", to_cnt); end
        total++; if (req_at != -1) begin bad++; $display("FAIL to_reissue got=%0d want=none", req_at); end
`endif
        fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(32'h500);
        @(negedge clk);
        fu.imem_valid = 1'b0;
        total++; if (fu.inst_valid !== 1'b1 || fu.inst !== mem_word(32'h500) || fu.pc !== 32'h500) begin
            bad++; $display("FAIL to_recover got=%b/%h/%h want=1/%h/00000500", fu.inst_valid, fu.inst, fu.pc, mem_word(32'h500));
        end
    endtask

    task automatic test_random();
        logic [31:0] model_pc;
        logic [31:0] pend_addr;
        logic [31:0] exp_word;
        logic [31:0] exp_p4;
        bit          pend, tainted, just_req, exp_hold, exp_req, do_redir, do_cons;
        int          pend_cnt;
        int          delivered;
        pend = 0; tainted = 0; exp_hold = 0; exp_req = 0; pend_cnt = 0; delivered = 0;
        pend_addr = 32'h0;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fu.redirect = 1'b1; fu.redirect_pc = 32'h0000_1237;
        model_pc = 32'h0000_1234;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            just_req = 0;
            if (exp_hold) begin
                total++; if (fu.inst_valid !== 1'b1) begin bad++; $display("FAIL rnd_resp_valid cyc=%0d got=%b want=1", cyc, fu.inst_valid); end
            end
            if (exp_req) begin
                total++; if (fu.imem_req !== 1'b1) begin bad++; $display("FAIL rnd_discard_req cyc=%0d got=%b want=1", cyc, fu.imem_req); end
            end
            if (fu.imem_req === 1'b1) begin
                total++; if (fu.imem_addr !== model_pc) begin bad++; $display("FAIL rnd_req_addr cyc=%0d got=%h want=%h", cyc, fu.imem_addr, model_pc); end
                pend = 1; pend_addr = fu.imem_addr; pend_cnt = int'($urandom_range(1, 5)); tainted = 0; just_req = 1;
            end
            if (fu.inst_valid === 1'b1) begin
                exp_word = mem_word(model_pc);
                exp_p4   = model_pc + 32'd4;
                total++; if (fu.inst !== exp_word || fu.pc !== model_pc || fu.pc_plus4 !== exp_p4 ||
                             fu.opcode !== exp_word[31:26] || fu.funct !== exp_word[5:0]) begin
                    bad++; $display("FAIL rnd_held cyc=%0d got=%h@%h want=%h@%h", cyc, fu.inst, fu.pc, exp_word, model_pc);
                end
                delivered++;
            end
            exp_hold = 0; exp_req = 0;
            do_redir = ($urandom_range(0, 7) == 0);
            do_cons  = ($urandom_range(0, 1) == 1);
            fu.redirect    = do_redir;
            fu.consume     = do_cons;
            fu.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            fu.imem_valid  = 1'b0;
            fu.imem_rdata  = $urandom;
            if (pend && !just_req) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    fu.imem_valid = 1'b1; fu.imem_rdata = mem_word(pend_addr); pend = 0;
                    if (tainted || do_redir) exp_req = 1; else exp_hold = 1;
                end
            end else if (!pend && fu.inst_valid === 1'b1 && $urandom_range(0, 2) == 0) begin
                fu.imem_valid = 1'b1; fu.imem_rdata = ~mem_word(model_pc);
            end
            if (do_redir) begin
                model_pc = fu.redirect_pc & 32'hFFFF_FFFC;
                if (pend) tainted = 1;
            end else if (do_cons && fu.inst_valid === 1'b1) begin
                model_pc = model_pc + 32'd4;
            end
            #1;
            total++; if (fu.fetch_timeout !== 1'b0) begin bad++; $display("FAIL rnd_timeout cyc=%0d got=%b want=0", cyc, fu.fetch_timeout); end
        end
        idle_inputs();
        total++; if (delivered < 100) begin bad++; $display("FAIL rnd_progress got=%0d want>=100", delivered); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_fetch();
        test_back_to_back();
        test_redirect();
        test_wrap();
        test_reset_midflight();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
